// File: rtl/bk_mouse_pkg.sv
// Shared types and bit positions for the BK 177714 mouse/joystick port.
package bk_mouse_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } axis_state_t;

  localparam int MB_UP        = 0;
  localparam int MB_RIGHT     = 1;
  localparam int MB_DOWN      = 2;
  localparam int MB_LEFT      = 3;
  localparam int MB_LBTN      = 5;
  localparam int MB_RBTN      = 6;
  localparam int MOUSE_EN_BIT = 3;

endpackage

// File: rtl/mouse_axis.sv
// One motion axis: saturating signed accumulator plus a latch-once direction FSM.
module mouse_axis
  import bk_mouse_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int ACC_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en,
  input  logic signed [8:0] delta,
  input  logic              clear,
  output logic              pos,
  output logic              neg
);

  // Two guard bits keep acc + delta - THRESH exact before clamping.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [SUM_W-1:0] THR     = SUM_W'(THRESH);

  axis_state_t             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    pos_d, neg_d;
  logic signed [SUM_W-1:0] acc_ext, add, adj, sum;

  assign acc_ext = SUM_W'(acc_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos;
    neg_d   = neg;
    add     = '0;
    adj     = '0;
    if (acc_en) add = SUM_W'(delta);
    if (state_q == IDLE) begin
      if (acc_ext >= THR) begin
        adj     = -THR;
        pos_d   = 1'b1;
        state_d = HELD;
      end else if (acc_ext <= -THR) begin
        adj     = THR;
        neg_d   = 1'b1;
        state_d = HELD;
      end
    end
    sum = acc_ext + add + adj;
    if (sum > ACC_MAX)      acc_d = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) acc_d = ACC_MIN[ACC_W-1:0];
    else                    acc_d = sum[ACC_W-1:0];
    if (clear) begin
      state_d = IDLE;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
      acc_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      pos     <= 1'b0;
      neg     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pos     <= pos_d;
      neg     <= neg_d;
    end
  end

endmodule

// File: rtl/mouse_port_wb.sv
// 177714 port source: joystick/mouse select, packet detect, enable and buttons.
module mouse_port_wb
  import bk_mouse_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int ACC_W  = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic signed [8:0] pointer_dx,
  input  logic signed [8:0] pointer_dy,
  input  logic [7:0]        mouse_counter,
  input  logic              left_btn,
  input  logic              right_btn,
  input  logic [7:0]        joystick,
  input  logic              port_wr,
  input  logic [7:0]        port_din,
  output logic [15:0]       port_data
);

  logic [7:0] cnt_q;
  logic       msel, en, lbtn, rbtn;
  logic       pkt, clear, acc_en;
  logic       up, down, right, left;
  logic [3:0] dir;
  logic       unused_din;

  assign unused_din = ^{port_din[7:4], port_din[2:0]};

  assign pkt    = (mouse_counter != cnt_q);
  assign clear  = port_wr && !port_din[MOUSE_EN_BIT];
  // A packet landing on a port write is dropped, whatever the written enable.
  assign acc_en = pkt && en && !port_wr;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      msel  <= 1'b0;
      en    <= 1'b0;
      lbtn  <= 1'b0;
      rbtn  <= 1'b0;
    end else begin
      cnt_q <= mouse_counter;
      lbtn  <= left_btn;
      rbtn  <= right_btn;
      if (joystick != 8'h00) msel <= 1'b0;
      else if (pkt)          msel <= 1'b1;
      if (port_wr) en <= port_din[MOUSE_EN_BIT];
    end
  end

  mouse_axis #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_x (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .acc_en (acc_en),
    .delta  (pointer_dx),
    .clear  (clear),
    .pos    (right),
    .neg    (left)
  );

  mouse_axis #(.THRESH(THRESH), .ACC_W(ACC_W)) u_axis_y (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .acc_en (acc_en),
    .delta  (pointer_dy),
    .clear  (clear),
    .pos    (up),
    .neg    (down)
  );

  always_comb begin
    dir           = '0;
    dir[MB_UP]    = up;
    dir[MB_RIGHT] = right;
    dir[MB_DOWN]  = down;
    dir[MB_LEFT]  = left;
    port_data     = {8'h00, joystick};
    if (msel) begin
      port_data          = '0;
      port_data[3:0]     = dir;
      port_data[MB_LBTN] = lbtn;
      port_data[MB_RBTN] = rbtn;
    end
  end

endmodule

// File: tb/tb_mouse_port_wb.sv
// Scoreboard bench for mouse_port_wb: stimulus queues expectations, a negedge monitor checks them.
module tb_mouse_port_wb;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [8:0] pointer_dx = '0;
  logic signed [8:0] pointer_dy = '0;
  logic [7:0]        mouse_counter = '0;
  logic              left_btn = 1'b0;
  logic              right_btn = 1'b0;
  logic [7:0]        joystick = '0;
  logic              port_wr = 1'b0;
  logic [7:0]        port_din = '0;
  logic [15:0]       port_data;

  mouse_port_wb #(.THRESH(4), .ACC_W(10)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .pointer_dx    (pointer_dx),
    .pointer_dy    (pointer_dy),
    .mouse_counter (mouse_counter),
    .left_btn      (left_btn),
    .right_btn     (right_btn),
    .joystick      (joystick),
    .port_wr       (port_wr),
    .port_din      (port_din),
    .port_data     (port_data)
  );

  always #5 clk = ~clk;

  typedef enum int { K_PD, K_ACCX, K_ACCY, K_MSEL, K_CNTQ } kind_t;
  typedef struct {
    int          due;
    kind_t       kind;
    logic [15:0] mask;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int off, input kind_t k, input logic [15:0] m,
                          input logic [15:0] e, input string n);
    exp_t x;
    x.due = cyc + off; x.kind = k; x.mask = m; x.exp = e & m; x.name = n;
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sample(input kind_t k);
    case (k)
      K_PD:    return port_data;
      K_ACCX:  return {6'b0, dut.u_axis_x.acc_q};
      K_ACCY:  return {6'b0, dut.u_axis_y.acc_q};
      K_MSEL:  return {15'b0, dut.msel};
      default: return {8'b0, dut.cnt_q};
    endcase
  endfunction

  task automatic check(input exp_t x, input logic [15:0] act, input bit late);
    n_cmp++;
    if (late || ((act & x.mask) !== x.exp)) begin
      n_bad++;
      $display("FAIL %s: got %h (masked %h) need %h%s", x.name, act, act & x.mask, x.exp,
               late ? " (missed sample)" : "");
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check(sb[i], sample(sb[i].kind), sb[i].due < cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    step(2);
    push_exp(0, K_PD, 16'hFFFF, 16'h0000, "reset_pd");
    push_exp(0, K_MSEL, 16'h0001, 16'h0000, "reset_msel");
    step(1);
    rst = 1'b0; joystick = 8'h05;
    push_exp(0, K_PD, 16'hFFFF, 16'h0005, "joy_pass");
    step(1);
    joystick = 8'h00; mouse_counter = 8'd1;
    push_exp(1, K_MSEL, 16'h0001, 16'h0001, "pkt_sets_msel");
    push_exp(1, K_PD, 16'hFFFF, 16'h0000, "mouse_idle_pd");
    step(2);

    port_wr = 1'b1; port_din = 8'h08;
    step(1);
    port_wr = 1'b0; mouse_counter = 8'd2; pointer_dy = 9'sd2;
    push_exp(1, K_ACCY, 16'h03FF, 16'h0002, "accy_first");
    step(1);
    mouse_counter = 8'd3;
    push_exp(1, K_ACCY, 16'h03FF, 16'h0004, "accy_second");
    push_exp(1, K_PD, 16'h000F, 16'h0000, "up_not_early");
    push_exp(2, K_PD, 16'h000F, 16'h0001, "up_set");
    push_exp(2, K_ACCY, 16'h03FF, 16'h0000, "accy_after_thr");
    step(4);

    pointer_dy = 9'sd0; pointer_dx = -9'sd9; mouse_counter = 8'd4;
    push_exp(1, K_ACCX, 16'h03FF, 16'h03F7, "accx_m9");
    push_exp(2, K_PD, 16'h000F, 16'h0009, "left_set");
    push_exp(2, K_ACCX, 16'h03FF, 16'h03FB, "accx_m5");
    step(4);
    port_wr = 1'b1; port_din = 8'h00;
    push_exp(1, K_PD, 16'h000F, 16'h0000, "clear_dir");
    push_exp(1, K_ACCX, 16'h03FF, 16'h0000, "clear_accx");
    push_exp(1, K_ACCY, 16'h03FF, 16'h0000, "clear_accy");
    step(1);
    port_wr = 1'b0; pointer_dx = 9'sd3; mouse_counter = 8'd5;
    push_exp(1, K_ACCX, 16'h03FF, 16'h0000, "disabled_accx");
    push_exp(2, K_PD, 16'h000F, 16'h0000, "disabled_dir");
    step(3);

    pointer_dx = 9'sd0; port_wr = 1'b1; port_din = 8'h08;
    step(1);
    port_wr = 1'b0; pointer_dy = 9'sd255;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] e;
      mouse_counter = 8'(6 + i);
      e = (i == 0) ? 16'd255 : (i == 1) ? 16'd506 : 16'd511;
      push_exp(1, K_ACCY, 16'h03FF, e, "accy_sat");
      step(1);
    end
    push_exp(0, K_PD, 16'h000F, 16'h0001, "sat_up_only");
    step(3);
    push_exp(0, K_PD, 16'h000F, 16'h0001, "sat_up_hold");
    push_exp(0, K_ACCY, 16'h03FF, 16'h01FF, "accy_at_max");
    push_exp(0, K_ACCX, 16'h03FF, 16'h0000, "accx_quiet");
    step(1);

    port_wr = 1'b1; port_din = 8'h00; pointer_dy = 9'sd100; mouse_counter = 8'd11;
    push_exp(1, K_PD, 16'h000F, 16'h0000, "wr_pkt_dir");
    push_exp(1, K_ACCY, 16'h03FF, 16'h0000, "wr_pkt_accy");
    push_exp(1, K_CNTQ, 16'h00FF, 16'h000B, "wr_pkt_cntq");
    step(1);
    port_wr = 1'b0;
    push_exp(2, K_ACCY, 16'h03FF, 16'h0000, "wr_pkt_drop");
    step(3);

    left_btn = 1'b1; right_btn = 1'b1;
    push_exp(0, K_PD, 16'hFFFF, 16'h0000, "btn_latency");
    push_exp(1, K_PD, 16'hFFFF, 16'h0060, "btn_both");
    step(2);
    left_btn = 1'b0; right_btn = 1'b0;
    push_exp(1, K_PD, 16'hFFFF, 16'h0000, "btn_release");
    step(2);

    joystick = 8'h10; mouse_counter = 8'd12;
    push_exp(0, K_PD, 16'hFFFF, 16'h0000, "joy_pre_msel");
    push_exp(1, K_PD, 16'hFFFF, 16'h0010, "joy_wins");
    push_exp(1, K_MSEL, 16'h0001, 16'h0000, "joy_wins_msel");
    step(2);
    joystick = 8'h00;
    push_exp(0, K_PD, 16'hFFFF, 16'h0000, "joy_off");
    step(1);

    port_wr = 1'b1; port_din = 8'h08;
    step(1);
    port_wr = 1'b0; pointer_dy = 9'sd0; pointer_dx = 9'sd5; mouse_counter = 8'd13;
    push_exp(2, K_PD, 16'h000F, 16'h0002, "right_set");
    push_exp(2, K_ACCX, 16'h03FF, 16'h0001, "accx_rem");
    step(3);
    rst = 1'b1;
    push_exp(0, K_PD, 16'hFFFF, 16'h0000, "midheld_rst_pd");
    push_exp(0, K_ACCX, 16'h03FF, 16'h0000, "midheld_rst_accx");
    step(2);
    rst = 1'b0; mouse_counter = 8'd14;
    push_exp(1, K_MSEL, 16'h0001, 16'h0001, "post_rst_msel");
    push_exp(1, K_ACCX, 16'h03FF, 16'h0000, "post_rst_accx");
    push_exp(2, K_PD, 16'h000F, 16'h0000, "post_rst_dir");
    step(1);

    for (int i = 0; i < 50 && sb.size() != 0; i++) step(1);
    while (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: never sampled, need %h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
